// File: rtl/mul8_seq_nibble_pkg.sv
// ---------------------------------------------------------------------------
// mul8_seq_nibble_pkg
// Shared types, widths and small arithmetic helpers for the nibble-serial
// 8x8 multiplier.
// ---------------------------------------------------------------------------
package mul8_seq_nibble_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } mul_state_t;

    localparam int OP_W    = 8;
    localparam int NIB_W   = 4;
    localparam int PROD_W  = 16;
    localparam int N_STEPS = 4;

    // Magnitude of an operand; -128 maps to 0x80, which still fits 8 bits unsigned.
    function automatic logic [OP_W-1:0] op_magnitude(input logic [OP_W-1:0] v,
                                                     input logic            use_sign);
        logic [OP_W-1:0] r;
        if (use_sign && v[OP_W-1]) begin
            r = (~v) + 8'd1;
        end else begin
            r = v;
        end
        return r;
    endfunction

    // Restore the product sign; negating zero yields zero, so 0 * negative stays 0x0000.
    function automatic logic [PROD_W-1:0] apply_sign(input logic [PROD_W-1:0] mag,
                                                     input logic              neg);
        logic [PROD_W-1:0] r;
        if (neg) begin
            r = (~mag) + 16'd1;
        end else begin
            r = mag;
        end
        return r;
    endfunction

endpackage

// File: rtl/mul8_seq_nibble_if.sv
// ---------------------------------------------------------------------------
// mul8_seq_nibble_if
// Operand / result handshake bundle for mul8_seq_nibble.
//   master : operand source + result consumer (drives in_valid, a, b, out_ready)
//   slave  : the multiplier (drives in_ready, out_valid, product, busy)
// ---------------------------------------------------------------------------
interface mul8_seq_nibble_if;
    import mul8_seq_nibble_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [OP_W-1:0]   a;
    logic [OP_W-1:0]   b;
    logic              out_valid;
    logic              out_ready;
    logic [PROD_W-1:0] product;
    logic              busy;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, product, busy
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, product, busy
    );

endinterface

// File: rtl/mul8_seq_nibble_i4bit_mul.sv
// ---------------------------------------------------------------------------
// i4bit_mul
// Combinational 4x4 unsigned multiplier core.
//   a [3:0] in  : multiplicand nibble
//   b [3:0] in  : multiplier nibble
//   s [7:0] out : a*b
// ---------------------------------------------------------------------------
module i4bit_mul
    import mul8_seq_nibble_pkg::*;
(
    input  logic [NIB_W-1:0]   a,
    input  logic [NIB_W-1:0]   b,
    output logic [2*NIB_W-1:0] s
);

    // Zero-extend both nibbles so the product is computed at full 8-bit width.
    assign s = {4'h0, a} * {4'h0, b};

endmodule

// File: rtl/mul8_seq_nibble.sv
// ---------------------------------------------------------------------------
// mul8_seq_nibble
// Multi-cycle 8x8 multiplier: one 4x4 core is reused over four steps, and the
// shifted nibble partial products are summed into a 16-bit accumulator.
// Parameters:
//   SIGNED : 0 = unsigned operands/result, 1 = two's complement (sign-magnitude inside)
// Ports:
//   clk   : clock, all state updates on the rising edge
//   rst_n : synchronous active-low reset
//   bus   : slave side of mul8_seq_nibble_if
//           in_valid/in_ready/a/b         operand handshake (accept only in IDLE)
//           out_valid/out_ready/product   result handshake, product held while valid
//           busy                          high in MUL or DONE
// Timing: accept at edge E0, out_valid after E4, next accept at E6 at the earliest.
// ---------------------------------------------------------------------------
module mul8_seq_nibble
    import mul8_seq_nibble_pkg::*;
#(
    parameter bit SIGNED = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mul8_seq_nibble_if.slave     bus
);

    localparam logic [1:0] LAST_STEP = 2'(N_STEPS - 1);

    mul_state_t          state_r;
    logic [1:0]          step_r;
    logic [OP_W-1:0]     a_mag_r;
    logic [OP_W-1:0]     b_mag_r;
    logic                sign_r;
    logic [PROD_W-1:0]   acc_r;
    logic [PROD_W-1:0]   product_r;
    logic                out_valid_r;
    logic                in_ready_r;
    logic                busy_r;

    logic [NIB_W-1:0]    core_a_s;
    logic [NIB_W-1:0]    core_b_s;
    logic [2*NIB_W-1:0]  pp_s;
    logic [PROD_W-1:0]   pp_shift_s;
    logic [PROD_W-1:0]   acc_next_s;

    // Select which nibble pair feeds the shared core in the current step.
    always_comb begin
        core_a_s = a_mag_r[3:0];
        core_b_s = b_mag_r[3:0];
        case (step_r)
            2'd0: begin
                core_a_s = a_mag_r[3:0];
                core_b_s = b_mag_r[3:0];
            end
            2'd1: begin
                core_a_s = a_mag_r[7:4];
                core_b_s = b_mag_r[3:0];
            end
            2'd2: begin
                core_a_s = a_mag_r[3:0];
                core_b_s = b_mag_r[7:4];
            end
            2'd3: begin
                core_a_s = a_mag_r[7:4];
                core_b_s = b_mag_r[7:4];
            end
            default: begin
                core_a_s = 4'h0;
                core_b_s = 4'h0;
            end
        endcase
    end

    i4bit_mul u_core (
        .a (core_a_s),
        .b (core_b_s),
        .s (pp_s)
    );

    // Align the partial product to its nibble weight and add it to the running sum.
    always_comb begin
        pp_shift_s = 16'h0000;
        case (step_r)
            2'd0:    pp_shift_s = {8'h00, pp_s};
            2'd1:    pp_shift_s = {4'h0, pp_s, 4'h0};
            2'd2:    pp_shift_s = {4'h0, pp_s, 4'h0};
            2'd3:    pp_shift_s = {pp_s, 8'h00};
            default: pp_shift_s = 16'h0000;
        endcase
        acc_next_s = acc_r + pp_shift_s;
    end

    // Control FSM, step counter, operand latches, accumulator and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            step_r      <= 2'd0;
            a_mag_r     <= 8'h00;
            b_mag_r     <= 8'h00;
            sign_r      <= 1'b0;
            acc_r       <= 16'h0000;
            product_r   <= 16'h0000;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            busy_r      <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    // in_ready_r is always high here, so in_valid alone is the accept.
                    if (bus.in_valid && in_ready_r) begin
                        state_r    <= MUL;
                        step_r     <= 2'd0;
                        acc_r      <= 16'h0000;
                        a_mag_r    <= op_magnitude(bus.a, SIGNED);
                        b_mag_r    <= op_magnitude(bus.b, SIGNED);
                        sign_r     <= SIGNED ? (bus.a[OP_W-1] ^ bus.b[OP_W-1]) : 1'b0;
                        in_ready_r <= 1'b0;
                        busy_r     <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                MUL: begin
                    acc_r  <= acc_next_s;
                    step_r <= step_r + 2'd1;
                    if (step_r == LAST_STEP) begin
                        state_r     <= DONE;
                        product_r   <= apply_sign(acc_next_s, sign_r);
                        out_valid_r <= 1'b1;
                    end else begin
                        state_r <= MUL;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state_r     <= IDLE;
                        out_valid_r <= 1'b0;
                        busy_r      <= 1'b0;
                        in_ready_r  <= 1'b1;
                    end else begin
                        state_r <= DONE;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    step_r      <= 2'd0;
                    out_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                    in_ready_r  <= 1'b1;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.product   = product_r;
    assign bus.busy      = busy_r;

endmodule

// File: tb/tb_mul8_seq_nibble.sv
// ---------------------------------------------------------------------------
// tb_mul8_seq_nibble
// Self-checking bench: one unsigned and one signed instance of the multiplier
// sharing clock and reset. Table-driven vectors plus directed sequences for
// backpressure, mid-operation reset and streaming throughput.
// ---------------------------------------------------------------------------
module tb_mul8_seq_nibble;

    logic clk;
    logic rst_n;

    int checks;
    int errors;

    mul8_seq_nibble_if if_u ();
    mul8_seq_nibble_if if_s ();

    mul8_seq_nibble #(.SIGNED(1'b0)) dut_u (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_u)
    );

    mul8_seq_nibble #(.SIGNED(1'b1)) dut_s (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          sgn;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h expected=0x%0h", nm, got, exp);
        end
    endtask

    task automatic drive(input bit sgn, input bit v, input logic [7:0] av,
                         input logic [7:0] bv, input bit ordy);
        if (sgn) begin
            if_s.in_valid = v; if_s.a = av; if_s.b = bv; if_s.out_ready = ordy;
        end else begin
            if_u.in_valid = v; if_u.a = av; if_u.b = bv; if_u.out_ready = ordy;
        end
    endtask

    function automatic logic get_ov(input bit sgn);
        return sgn ? if_s.out_valid : if_u.out_valid;
    endfunction

    function automatic logic [15:0] get_prod(input bit sgn);
        return sgn ? if_s.product : if_u.product;
    endfunction

    function automatic logic get_ir(input bit sgn);
        return sgn ? if_s.in_ready : if_u.in_ready;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full transaction with out_ready held high; checks latency and product.
    task automatic do_op(input bit sgn, input logic [7:0] av, input logic [7:0] bv,
                         input logic [15:0] exp, input string nm);
        int lat;
        lat = 0;
        chk({nm, "_in_ready"}, {31'd0, get_ir(sgn)}, 32'd1);
        drive(sgn, 1'b1, av, bv, 1'b1);
        tick();
        drive(sgn, 1'b0, 8'h00, 8'h00, 1'b1);
        for (int i = 1; i <= 10 && lat == 0; i++) begin
            tick();
            if (get_ov(sgn)) lat = i;
        end
        chk({nm, "_latency"}, lat, 32'd4);
        chk({nm, "_product"}, {16'd0, get_prod(sgn)}, {16'd0, exp});
        tick();
        chk({nm, "_ov_drop"}, {31'd0, get_ov(sgn)}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    logic [15:0] q[$];
    logic [15:0] exp_v;
    int          n_acc;
    int          n_res;
    int          last_acc;
    bit          acc_now;

    initial begin
        checks = 0;
        errors = 0;

        vecs[0] = '{1'b0, 8'hFF, 8'hFF, 16'hFE01, "u_ff_ff"};
        vecs[1] = '{1'b0, 8'h00, 8'hAB, 16'h0000, "u_00_ab"};
        vecs[2] = '{1'b0, 8'h12, 8'h34, 16'h03A8, "u_12_34"};
        vecs[3] = '{1'b0, 8'h80, 8'h80, 16'h4000, "u_80_80"};
        vecs[4] = '{1'b1, 8'h80, 8'h80, 16'h4000, "s_m128_m128"};
        vecs[5] = '{1'b1, 8'hFF, 8'h01, 16'hFFFF, "s_m1_1"};
        vecs[6] = '{1'b1, 8'h7F, 8'h80, 16'hC080, "s_127_m128"};
        vecs[7] = '{1'b1, 8'h00, 8'hFB, 16'h0000, "s_0_m5"};
        vecs[8] = '{1'b1, 8'hFD, 8'h05, 16'hFFF1, "s_m3_5"};
        vecs[9] = '{1'b1, 8'hFD, 8'hFB, 16'h000F, "s_m3_m5"};

        drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        drive(1'b1, 1'b0, 8'h00, 8'h00, 1'b0);

        // Reset held two cycles
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        chk("rst_u_in_ready",  {31'd0, if_u.in_ready},  32'd1);
        chk("rst_u_out_valid", {31'd0, if_u.out_valid}, 32'd0);
        chk("rst_u_busy",      {31'd0, if_u.busy},      32'd0);
        chk("rst_u_product",   {16'd0, if_u.product},   32'd0);
        chk("rst_s_in_ready",  {31'd0, if_s.in_ready},  32'd1);
        chk("rst_s_product",   {16'd0, if_s.product},   32'd0);

        // Table-driven vectors
        for (int i = 0; i < 10; i++) begin
            do_op(vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].name);
        end

        // Backpressure: result held, competing operands ignored
        drive(1'b0, 1'b1, 8'h0F, 8'h10, 1'b0);
        tick();
        drive(1'b0, 1'b1, 8'h01, 8'h01, 1'b0);
        chk("bp_busy_after_accept", {31'd0, if_u.busy}, 32'd1);
        for (int i = 0; i < 4; i++) tick();
        for (int i = 0; i < 5; i++) begin
            chk("bp_out_valid", {31'd0, if_u.out_valid}, 32'd1);
            chk("bp_product",   {16'd0, if_u.product},   32'h00F0);
            chk("bp_in_ready",  {31'd0, if_u.in_ready},  32'd0);
            tick();
        end
        drive(1'b0, 1'b0, 8'h01, 8'h01, 1'b1);
        tick();
        chk("bp_release_ov",   {31'd0, if_u.out_valid}, 32'd0);
        chk("bp_release_ir",   {31'd0, if_u.in_ready},  32'd1);
        chk("bp_release_busy", {31'd0, if_u.busy},      32'd0);
        chk("bp_idle_product", {16'd0, if_u.product},   32'h00F0);
        drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        tick();

        // out_ready while idle is ignored: no spurious result
        drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
        tick();
        tick();
        chk("idle_ordy_ov", {31'd0, if_u.out_valid}, 32'd0);

        // Reset during step 2 of 0xFF*0xFF
        drive(1'b0, 1'b1, 8'hFF, 8'hFF, 1'b1);
        tick();
        drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("midrst_ov",      {31'd0, if_u.out_valid}, 32'd0);
        chk("midrst_ir",      {31'd0, if_u.in_ready},  32'd1);
        chk("midrst_busy",    {31'd0, if_u.busy},      32'd0);
        chk("midrst_product", {16'd0, if_u.product},   32'd0);
        for (int i = 0; i < 4; i++) tick();
        chk("midrst_no_late_ov", {31'd0, if_u.out_valid}, 32'd0);
        do_op(1'b0, 8'h03, 8'h05, 16'h000F, "midrst_next_3x5");

        // Streaming: in_valid and out_ready held high
        n_acc    = 0;
        n_res    = 0;
        last_acc = 0;
        drive(1'b0, 1'b1, 8'($urandom_range(255)), 8'($urandom_range(255)), 1'b1);
        for (int cyc = 0; cyc < 800 && n_res < 100; cyc++) begin
            acc_now = if_u.in_ready && if_u.in_valid && (n_acc < 100);
            if (if_u.out_valid) begin
                if (q.size() == 0) begin
                    chk("stream_unexpected_result", 32'd1, 32'd0);
                end else begin
                    exp_v = q.pop_front();
                    chk("stream_product", {16'd0, if_u.product}, {16'd0, exp_v});
                end
                n_res++;
            end
            if (acc_now) begin
                q.push_back(16'(if_u.a) * 16'(if_u.b));
                if (n_acc > 0) chk("stream_interval", cyc - last_acc, 32'd6);
                last_acc = cyc;
                n_acc++;
            end
            tick();
            if (acc_now) begin
                if (n_acc >= 100) begin
                    drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
                end else begin
                    drive(1'b0, 1'b1, 8'($urandom_range(255)), 8'($urandom_range(255)), 1'b1);
                end
            end
        end
        chk("stream_results", n_res, 32'd100);
        chk("stream_queue_empty", q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
